// File: rtl/post_proc_responder.sv
// Scans the detection output memory, hands valid faces downstream and clears the OM on request.
// Optional: define POSTP_MERGE_EN to drop entries that sit within 2 px of the last emitted face.
module post_proc_responder #(
   parameter int OM_DEPTH = 256,
   parameter int ADDR_W   = 8
) (
   input  logic              iClk,
   input  logic              iReset_n,
   input  logic              iRun_PostP,
   input  logic              iRun_Set_OM,
   output logic              oOM_rd_en,
   output logic [ADDR_W-1:0] oOM_rd_addr,
   input  logic [31:0]       iOM_rd_data,
   output logic              oOM_wr_en,
   output logic [ADDR_W-1:0] oOM_wr_addr,
   output logic [31:0]       oOM_wr_data,
   output logic              oFace_valid,
   input  logic              iFace_ready,
   output logic [9:0]        oFace_x,
   output logic [9:0]        oFace_y,
   output logic [4:0]        oFace_size,
   output logic [7:0]        oFace_count,
   output logic              oFinish_PostP,
   output logic              oFinish_Set_OM,
   output logic              oBusy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_EMIT,
      S_DONE,
      S_CLEAR,
      S_CLR_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(OM_DEPTH - 1);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              r_run_prev;
   logic [9:0]        r_face_x;
   logic [9:0]        r_face_y;
   logic [4:0]        r_face_size;
   logic [7:0]        r_count;

   logic              w_rise;
   logic              w_last_addr;
   logic              w_ent_vld;
   logic [1:0]        w_ent_scale;
   logic [9:0]        w_ent_x;
   logic [9:0]        w_ent_y;
   logic [4:0]        w_size;
   logic              w_merge_hit;
   logic              w_accept;
   logic              w_capture;
   logic              w_cnt_inc;
   logic              w_cnt_clr;
   logic              w_scan_start;
   logic              w_unused;

   assign w_rise      = iRun_PostP & ~r_run_prev;
   assign w_last_addr = (r_addr == LP_LAST);
   assign w_ent_vld   = iOM_rd_data[31];
   assign w_ent_scale = iOM_rd_data[21:20];
   assign w_ent_x     = iOM_rd_data[19:10];
   assign w_ent_y     = iOM_rd_data[9:0];
   assign w_unused    = &{1'b0, iOM_rd_data[30:22]};

   always_comb begin
      w_size = 5'd0;
      unique case (w_ent_scale)
         2'd0:    w_size = 5'd23;
         2'd1:    w_size = 5'd19;
         2'd2:    w_size = 5'd17;
         default: w_size = 5'd0;
      endcase
   end

`ifdef POSTP_MERGE_EN
   logic        r_last_vld;
   logic [1:0]  r_last_scale;
   logic [9:0]  r_last_x;
   logic [9:0]  r_last_y;
   logic [10:0] w_dx;
   logic [10:0] w_dy;
   logic        w_near_x;
   logic        w_near_y;

   // 11-bit two's complement difference: near means -2..+2
   assign w_dx     = {1'b0, w_ent_x} - {1'b0, r_last_x};
   assign w_dy     = {1'b0, w_ent_y} - {1'b0, r_last_y};
   assign w_near_x = (w_dx <= 11'd2) || (w_dx >= 11'h7FE);
   assign w_near_y = (w_dy <= 11'd2) || (w_dy >= 11'h7FE);

   assign w_merge_hit = r_last_vld
                     && (w_ent_scale == r_last_scale)
                     && w_near_x
                     && w_near_y;

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         r_last_vld   <= 1'b0;
         r_last_scale <= 2'd0;
         r_last_x     <= 10'd0;
         r_last_y     <= 10'd0;
      end else if (w_scan_start) begin
         r_last_vld   <= 1'b0;
      end else if (w_capture) begin
         r_last_vld   <= 1'b1;
         r_last_scale <= w_ent_scale;
         r_last_x     <= w_ent_x;
         r_last_y     <= w_ent_y;
      end
   end
`else
   assign w_merge_hit = 1'b0;
`endif

   assign w_accept = w_ent_vld
                  && (w_ent_scale != 2'd3)
                  && !w_merge_hit;

   always_comb begin
      w_next       = r_state;
      w_addr_nxt   = r_addr;
      w_capture    = 1'b0;
      w_cnt_inc    = 1'b0;
      w_cnt_clr    = 1'b0;
      w_scan_start = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_addr_nxt = '0;
            if (w_rise) begin
               w_next       = S_READ;
               w_cnt_clr    = 1'b1;
               w_scan_start = 1'b1;
            end else if (iRun_Set_OM) begin
               w_next = S_CLEAR;
            end
         end
         S_READ: begin
            w_next = S_WAIT;
         end
         S_WAIT: begin
            if (w_accept) begin
               w_next    = S_EMIT;
               w_capture = 1'b1;
            end else if (w_last_addr) begin
               w_next = S_DONE;
            end else begin
               w_next     = S_READ;
               w_addr_nxt = r_addr + ADDR_W'(1);
            end
         end
         S_EMIT: begin
            if (iFace_ready) begin
               w_cnt_inc = 1'b1;
               if (w_last_addr) begin
                  w_next = S_DONE;
               end else begin
                  w_next     = S_READ;
                  w_addr_nxt = r_addr + ADDR_W'(1);
               end
            end
         end
         S_DONE: begin
            w_addr_nxt = '0;
            w_next     = iRun_Set_OM ? S_CLEAR : S_IDLE;
         end
         S_CLEAR: begin
            if (w_last_addr) begin
               w_next     = S_CLR_DONE;
               w_addr_nxt = '0;
            end else begin
               w_addr_nxt = r_addr + ADDR_W'(1);
            end
         end
         S_CLR_DONE: begin
            w_next    = S_IDLE;
            w_cnt_clr = 1'b1;
         end
         default: begin
            w_next     = S_IDLE;
            w_addr_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_run_prev <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_addr     <= w_addr_nxt;
         r_run_prev <= iRun_PostP;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         r_face_x    <= 10'd0;
         r_face_y    <= 10'd0;
         r_face_size <= 5'd0;
      end else if (w_capture) begin
         r_face_x    <= w_ent_x;
         r_face_y    <= w_ent_y;
         r_face_size <= w_size;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         r_count <= 8'd0;
      end else if (w_cnt_clr) begin
         r_count <= 8'd0;
      end else if (w_cnt_inc && (r_count != 8'hFF)) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign oOM_rd_en      = (r_state == S_READ);
   assign oOM_rd_addr    = r_addr;
   assign oOM_wr_en      = (r_state == S_CLEAR);
   assign oOM_wr_addr    = r_addr;
   assign oOM_wr_data    = 32'd0;
   assign oFace_valid    = (r_state == S_EMIT);
   assign oFace_x        = r_face_x;
   assign oFace_y        = r_face_y;
   assign oFace_size     = r_face_size;
   assign oFace_count    = r_count;
   assign oFinish_PostP  = (r_state == S_DONE);
   assign oFinish_Set_OM = (r_state == S_CLR_DONE);
   assign oBusy          = (r_state != S_IDLE);

endmodule
